zic_nest_ctrl: RTL and testbench

- Claim/complete sequencer for the ZIC interrupt controller.
- Sits between the interrupt request generator and the core. Latches the outstanding request, services the core's claim, and clears the pending bit at the gateway.
- Holds a LIFO of in-service {id, level} pairs. Its top drives the active level that the request generator compares against, which gives preemptive nesting.
- Pops the LIFO on end-of-interrupt (EOI) from the core.

---
 rtl/zic_pkg.sv | 18 +
 rtl/zic_lvl_stack.sv | 96 +++++++++
 rtl/zic_nest_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_zic_nest_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/zic_pkg.sv
// Shared widths, priority slice and FSM encoding for the ZIC nesting
// controller.
package zic_pkg;

    localparam int ZIC_ID_W       = 8;
    localparam int ZIC_LVL_W      = 8;
    localparam int ZIC_LVL_HI     = 7;
    localparam int ZIC_LVL_LO     = 5;
    localparam int ZIC_NEST_DEPTH = 8;
    localparam int ZIC_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        SETTLE = 2'd2
    } nest_state_t;

endpackage

// File: rtl/zic_lvl_stack.sv
// LIFO of in-service {id, level} pairs.
// The top entry is kept in its own register so the outputs come straight from flops.
module zic_lvl_stack
    import zic_pkg::*;
#(
    parameter int DEPTH = ZIC_NEST_DEPTH,
    parameter int ID_W  = ZIC_ID_W,
    parameter int LVL_W = ZIC_LVL_W,
    parameter int CNT_W = ZIC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [ID_W-1:0]  push_id_i,
    input  logic [LVL_W-1:0] push_lvl_i,
    input  logic             pop_i,
    output logic [ID_W-1:0]  top_id_o,
    output logic [LVL_W-1:0] top_lvl_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ID_W-1:0]  id_q  [DEPTH];
    logic [ID_W-1:0]  id_d  [DEPTH];
    logic [LVL_W-1:0] lvl_q [DEPTH];
    logic [LVL_W-1:0] lvl_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  top_id_q, top_id_d;
    logic [LVL_W-1:0] top_lvl_q, top_lvl_d;
    logic [IDX_W-1:0] wr_idx, prev_idx;

    assign full_o    = (cnt_q == CNT_W'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign count_o   = cnt_q;
    assign top_id_o  = top_id_q;
    assign top_lvl_o = top_lvl_q;

    assign wr_idx   = IDX_W'(cnt_q);
    assign prev_idx = IDX_W'(cnt_q - CNT_W'(2));

    always_comb begin
        id_d      = id_q;
        lvl_d     = lvl_q;
        cnt_d     = cnt_q;
        top_id_d  = top_id_q;
        top_lvl_d = top_lvl_q;
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_d[i]  = '0;
                lvl_d[i] = '0;
            end
            cnt_d     = '0;
            top_id_d  = '0;
            top_lvl_d = '0;
        end else if (push_i && !full_o) begin
            id_d[wr_idx]  = push_id_i;
            lvl_d[wr_idx] = push_lvl_i;
            cnt_d         = cnt_q + CNT_W'(1);
            top_id_d      = push_id_i;
            top_lvl_d     = push_lvl_i;
        end else if (pop_i && !empty_o) begin
            cnt_d = cnt_q - CNT_W'(1);
            // Expose the entry below, or 0 once the stack drains.
            if (cnt_q >= CNT_W'(2)) begin
                top_id_d  = id_q[prev_idx];
                top_lvl_d = lvl_q[prev_idx];
            end else begin
                top_id_d  = '0;
                top_lvl_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]  <= '0;
                lvl_q[i] <= '0;
            end
            cnt_q     <= '0;
            top_id_q  <= '0;
            top_lvl_q <= '0;
        end else begin
            id_q      <= id_d;
            lvl_q     <= lvl_d;
            cnt_q     <= cnt_d;
            top_id_q  <= top_id_d;
            top_lvl_q <= top_lvl_d;
        end
    end

endmodule

// File: rtl/zic_nest_ctrl.sv
// Claim/complete sequencer for the ZIC: snapshots the pending request,
// answers core claims, clears the gateway and tracks nesting via a LIFO.
module zic_nest_ctrl
    import zic_pkg::*;
#(
    parameter int NEST_DEPTH = ZIC_NEST_DEPTH,
    parameter int ID_W       = ZIC_ID_W,
    parameter int LVL_W      = ZIC_LVL_W,
    parameter int CNT_W      = ZIC_CNT_W
) (
    input  logic             zic_clk,
    input  logic             zic_rst,
    input  logic             wdt_reset_i,
    input  logic             debug_ndm_reset_i,
    input  logic             irq_req_i,
    input  logic             irq_id_valid_i,
    input  logic [ID_W-1:0]  irq_id_i,
    input  logic [LVL_W-1:0] irq_lvl_i,
    input  logic             claim_i,
    output logic             claim_valid_o,
    output logic [ID_W-1:0]  claim_id_o,
    output logic             clr_pending_o,
    output logic [ID_W-1:0]  clr_id_o,
    input  logic             eoi_i,
    input  logic [ID_W-1:0]  eoi_id_i,
    output logic [LVL_W-1:0] active_lvl_o,
    output logic [ID_W-1:0]  active_id_o,
    output logic [CNT_W-1:0] nest_depth_o,
    output logic             stack_ovf_o,
    output logic             eoi_err_o
);

    nest_state_t      state_q, state_d;
    logic [ID_W-1:0]  snap_id_q, snap_id_d;
    logic [LVL_W-1:0] snap_lvl_q, snap_lvl_d;
    logic             eoi_hold_q, eoi_hold_d;
    logic [ID_W-1:0]  eoi_hold_id_q, eoi_hold_id_d;
    logic             claim_valid_q, claim_valid_d;
    logic [ID_W-1:0]  claim_id_q, claim_id_d;
    logic             clr_pending_q, clr_pending_d;
    logic [ID_W-1:0]  clr_id_q, clr_id_d;
    logic             stack_ovf_q, stack_ovf_d;
    logic             eoi_err_q, eoi_err_d;

    logic             sync_clr;
    logic             req_ok;
    logic             push, pop;
    logic             eoi_go;
    logic [ID_W-1:0]  eoi_tag;
    logic [ID_W-1:0]  stk_top_id;
    logic             stk_full, stk_empty;

    assign sync_clr = wdt_reset_i || debug_ndm_reset_i;
    assign req_ok   = irq_req_i && irq_id_valid_i;

    zic_lvl_stack #(
        .DEPTH (NEST_DEPTH),
        .ID_W  (ID_W),
        .LVL_W (LVL_W),
        .CNT_W (CNT_W)
    ) u_stack (
        .clk        (zic_clk),
        .rst_n      (zic_rst),
        .clr_i      (sync_clr),
        .push_i     (push),
        .push_id_i  (snap_id_q),
        .push_lvl_i (snap_lvl_q),
        .pop_i      (pop),
        .top_id_o   (stk_top_id),
        .top_lvl_o  (active_lvl_o),
        .count_o    (nest_depth_o),
        .full_o     (stk_full),
        .empty_o    (stk_empty)
    );

    always_comb begin
        state_d       = state_q;
        snap_id_d     = snap_id_q;
        snap_lvl_d    = snap_lvl_q;
        eoi_hold_d    = eoi_hold_q;
        eoi_hold_id_d = eoi_hold_id_q;
        claim_valid_d = 1'b0;
        claim_id_d    = '0;
        clr_pending_d = 1'b0;
        clr_id_d      = '0;
        stack_ovf_d   = stack_ovf_q;
        eoi_err_d     = eoi_err_q;
        push          = 1'b0;
        pop           = 1'b0;
        eoi_go        = eoi_i;
        eoi_tag       = eoi_id_i;

        unique case (state_q)
            IDLE: begin
                claim_valid_d = claim_i;
                if (req_ok) begin
                    snap_id_d  = irq_id_i;
                    snap_lvl_d = irq_lvl_i;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (req_ok) begin
                    snap_id_d  = irq_id_i;
                    snap_lvl_d = irq_lvl_i;
                end
                if (claim_i && !stk_full) begin
                    push          = 1'b1;
                    claim_valid_d = 1'b1;
                    claim_id_d    = snap_id_q;
                    clr_pending_d = 1'b1;
                    clr_id_d      = snap_id_q;
                    // A same-edge EOI is deferred so push and pop never collide.
                    eoi_go        = 1'b0;
                    eoi_hold_d    = eoi_i;
                    eoi_hold_id_d = eoi_id_i;
                    state_d       = SETTLE;
                end else if (claim_i) begin
                    claim_valid_d = 1'b1;
                    stack_ovf_d   = 1'b1;
                    state_d       = IDLE;
                end else if (!irq_req_i) begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                claim_valid_d = claim_i;
                if (eoi_hold_q) begin
                    eoi_go  = 1'b1;
                    eoi_tag = eoi_hold_id_q;
                    // Only one pop per edge; a fresh EOI here is dropped.
                    if (eoi_i) eoi_err_d = 1'b1;
                end
                eoi_hold_d    = 1'b0;
                eoi_hold_id_d = '0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (eoi_go) begin
            if (stk_empty || (eoi_tag != stk_top_id)) eoi_err_d = 1'b1;
            else pop = 1'b1;
        end

        if (sync_clr) begin
            state_d       = IDLE;
            snap_id_d     = '0;
            snap_lvl_d    = '0;
            eoi_hold_d    = 1'b0;
            eoi_hold_id_d = '0;
            claim_valid_d = 1'b0;
            claim_id_d    = '0;
            clr_pending_d = 1'b0;
            clr_id_d      = '0;
            stack_ovf_d   = 1'b0;
            eoi_err_d     = 1'b0;
            push          = 1'b0;
            pop           = 1'b0;
        end
    end

    always_ff @(posedge zic_clk or negedge zic_rst) begin
        if (!zic_rst) begin
            state_q       <= IDLE;
            snap_id_q     <= '0;
            snap_lvl_q    <= '0;
            eoi_hold_q    <= 1'b0;
            eoi_hold_id_q <= '0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            clr_pending_q <= 1'b0;
            clr_id_q      <= '0;
            stack_ovf_q   <= 1'b0;
            eoi_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_id_q     <= snap_id_d;
            snap_lvl_q    <= snap_lvl_d;
            eoi_hold_q    <= eoi_hold_d;
            eoi_hold_id_q <= eoi_hold_id_d;
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
            clr_pending_q <= clr_pending_d;
            clr_id_q      <= clr_id_d;
            stack_ovf_q   <= stack_ovf_d;
            eoi_err_q     <= eoi_err_d;
        end
    end

    assign claim_valid_o = claim_valid_q;
    assign claim_id_o    = claim_id_q;
    assign clr_pending_o = clr_pending_q;
    assign clr_id_o      = clr_id_q;
    assign active_id_o   = stk_top_id;
    assign stack_ovf_o   = stack_ovf_q;
    assign eoi_err_o     = eoi_err_q;

endmodule

// File: tb/tb_zic_nest_ctrl.sv
// Directed bench for zic_nest_ctrl: a default-depth instance plus a
// depth-2 instance sharing the same stimulus for the overflow case.
module tb_zic_nest_ctrl;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       wdt    = 1'b0;
    logic       ndm    = 1'b0;
    logic       req    = 1'b0;
    logic       idv    = 1'b0;
    logic       claim  = 1'b0;
    logic       eoi    = 1'b0;
    logic [7:0] id     = '0;
    logic [7:0] lvl    = '0;
    logic [7:0] eoi_id = '0;

    logic       a_cv, a_clr, a_ovf, a_err;
    logic [7:0] a_cid, a_clrid, a_alvl, a_aid;
    logic [3:0] a_dep;
    logic       b_cv, b_clr, b_ovf, b_err;
    logic [7:0] b_cid, b_clrid, b_alvl, b_aid;
    logic [3:0] b_dep;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    zic_nest_ctrl u_dut (
        .zic_clk           (clk),
        .zic_rst           (rst_n),
        .wdt_reset_i       (wdt),
        .debug_ndm_reset_i (ndm),
        .irq_req_i         (req),
        .irq_id_valid_i    (idv),
        .irq_id_i          (id),
        .irq_lvl_i         (lvl),
        .claim_i           (claim),
        .claim_valid_o     (a_cv),
        .claim_id_o        (a_cid),
        .clr_pending_o     (a_clr),
        .clr_id_o          (a_clrid),
        .eoi_i             (eoi),
        .eoi_id_i          (eoi_id),
        .active_lvl_o      (a_alvl),
        .active_id_o       (a_aid),
        .nest_depth_o      (a_dep),
        .stack_ovf_o       (a_ovf),
        .eoi_err_o         (a_err)
    );

    zic_nest_ctrl #(.NEST_DEPTH(2)) u_dut2 (
        .zic_clk           (clk),
        .zic_rst           (rst_n),
        .wdt_reset_i       (wdt),
        .debug_ndm_reset_i (ndm),
        .irq_req_i         (req),
        .irq_id_valid_i    (idv),
        .irq_id_i          (id),
        .irq_lvl_i         (lvl),
        .claim_i           (claim),
        .claim_valid_o     (b_cv),
        .claim_id_o        (b_cid),
        .clr_pending_o     (b_clr),
        .clr_id_o          (b_clrid),
        .eoi_i             (eoi),
        .eoi_id_i          (eoi_id),
        .active_lvl_o      (b_alvl),
        .active_id_o       (b_aid),
        .nest_depth_o      (b_dep),
        .stack_ovf_o       (b_ovf),
        .eoi_err_o         (b_err)
    );

    typedef struct {
        logic        claim;
        logic        eoi;
        logic [7:0]  eoi_id;
        logic        req;
        logic [7:0]  id;
        logic [7:0]  lvl;
        logic        wdt;
        logic        ndm;
        logic [39:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [39:0] pk(
        input logic cv, input logic [7:0] cid,
        input logic clr, input logic [7:0] clrid,
        input logic [7:0] al, input logic [7:0] ai,
        input logic [3:0] d, input logic o, input logic e);
        return {cv, cid, clr, clrid, al, ai, d, o, e};
    endfunction

    function automatic logic [39:0] act_a();
        return pk(a_cv, a_cid, a_clr, a_clrid, a_alvl, a_aid, a_dep, a_ovf, a_err);
    endfunction

    function automatic logic [39:0] act_b();
        return pk(b_cv, b_cid, b_clr, b_clrid, b_alvl, b_aid, b_dep, b_ovf, b_err);
    endfunction

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(
        input logic c, input logic e, input logic [7:0] eid,
        input logic r, input logic [7:0] i, input logic [7:0] l,
        input logic w, input logic n,
        input logic cv, input logic [7:0] cid,
        input logic clr, input logic [7:0] clrid,
        input logic [7:0] al, input logic [7:0] ai,
        input logic [3:0] d, input logic o, input logic er);
        vec_t v;
        v.claim  = c;
        v.eoi    = e;
        v.eoi_id = eid;
        v.req    = r;
        v.id     = i;
        v.lvl    = l;
        v.wdt    = w;
        v.ndm    = n;
        v.exp    = pk(cv, cid, clr, clrid, al, ai, d, o, er);
        tbl.push_back(v);
    endtask

    task automatic step(
        input logic c, input logic e, input logic [7:0] eid,
        input logic r, input logic [7:0] i, input logic [7:0] l,
        input logic w, input logic n);
        claim  = c;
        eoi    = e;
        eoi_id = eid;
        req    = r;
        idv    = r;
        id     = i;
        lvl    = l;
        wdt    = w;
        ndm    = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // claim eoi eid  req id   lvl  wdt ndm | cv cid clr clrid alvl aid dep ovf err
        add(0,0,8'h00, 0,8'h00,8'h00, 0,0, 0,8'h00,0,8'h00, 8'h00,8'h00,0,0,0);
        add(0,0,8'h00, 1,8'h12,8'h40, 0,0, 0,8'h00,0,8'h00, 8'h00,8'h00,0,0,0);
        add(1,0,8'h00, 1,8'h12,8'h40, 0,0, 1,8'h12,1,8'h12, 8'h40,8'h12,1,0,0);
        add(0,0,8'h00, 0,8'h00,8'h00, 0,0, 0,8'h00,0,8'h00, 8'h40,8'h12,1,0,0);
        add(0,0,8'h00, 1,8'h20,8'hA0, 0,0, 0,8'h00,0,8'h00, 8'h40,8'h12,1,0,0);
        add(1,0,8'h00, 1,8'h20,8'hA0, 0,0, 1,8'h20,1,8'h20, 8'hA0,8'h20,2,0,0);
        add(0,0,8'h00, 0,8'h00,8'h00, 0,0, 0,8'h00,0,8'h00, 8'hA0,8'h20,2,0,0);
        add(0,1,8'h20, 0,8'h00,8'h00, 0,0, 0,8'h00,0,8'h00, 8'h40,8'h12,1,0,0);
        add(0,1,8'h05, 0,8'h00,8'h00, 0,0, 0,8'h00,0,8'h00, 8'h40,8'h12,1,0,1);
        add(0,1,8'h12, 0,8'h00,8'h00, 0,0, 0,8'h00,0,8'h00, 8'h00,8'h00,0,0,1);
        add(0,1,8'h33, 0,8'h00,8'h00, 0,0, 0,8'h00,0,8'h00, 8'h00,8'h00,0,0,1);
        add(1,0,8'h00, 0,8'h00,8'h00, 0,0, 1,8'h00,0,8'h00, 8'h00,8'h00,0,0,1);
        add(0,0,8'h00, 1,8'h07,8'h20, 0,0, 0,8'h00,0,8'h00, 8'h00,8'h00,0,0,1);
        add(0,0,8'h00, 0,8'h00,8'h00, 0,0, 0,8'h00,0,8'h00, 8'h00,8'h00,0,0,1);
        add(1,0,8'h00, 0,8'h00,8'h00, 0,0, 1,8'h00,0,8'h00, 8'h00,8'h00,0,0,1);
        add(0,0,8'h00, 0,8'h00,8'h00, 0,1, 0,8'h00,0,8'h00, 8'h00,8'h00,0,0,0);
        add(0,0,8'h00, 1,8'h30,8'h60, 0,0, 0,8'h00,0,8'h00, 8'h00,8'h00,0,0,0);
        add(0,0,8'h00, 1,8'h31,8'h80, 0,0, 0,8'h00,0,8'h00, 8'h00,8'h00,0,0,0);
        add(1,0,8'h00, 1,8'h31,8'h80, 0,0, 1,8'h31,1,8'h31, 8'h80,8'h31,1,0,0);
        add(0,0,8'h00, 1,8'h40,8'h90, 0,0, 0,8'h00,0,8'h00, 8'h80,8'h31,1,0,0);
        add(0,0,8'h00, 1,8'h40,8'h90, 0,0, 0,8'h00,0,8'h00, 8'h80,8'h31,1,0,0);
        add(1,1,8'h40, 1,8'h40,8'h90, 0,0, 1,8'h40,1,8'h40, 8'h90,8'h40,2,0,0);
        add(0,0,8'h00, 0,8'h00,8'h00, 0,0, 0,8'h00,0,8'h00, 8'h80,8'h31,1,0,0);
        add(0,0,8'h00, 1,8'h41,8'hA0, 0,0, 0,8'h00,0,8'h00, 8'h80,8'h31,1,0,0);
        add(1,1,8'h31, 1,8'h41,8'hA0, 0,0, 1,8'h41,1,8'h41, 8'hA0,8'h41,2,0,0);
        add(0,0,8'h00, 0,8'h00,8'h00, 0,0, 0,8'h00,0,8'h00, 8'hA0,8'h41,2,0,1);
        add(0,0,8'h00, 1,8'h50,8'hC0, 0,0, 0,8'h00,0,8'h00, 8'hA0,8'h41,2,0,1);
        add(1,0,8'h00, 1,8'h50,8'hC0, 0,0, 1,8'h50,1,8'h50, 8'hC0,8'h50,3,0,1);
        add(0,0,8'h00, 1,8'h51,8'hD0, 0,0, 0,8'h00,0,8'h00, 8'hC0,8'h50,3,0,1);
        add(0,0,8'h00, 1,8'h51,8'hD0, 0,0, 0,8'h00,0,8'h00, 8'hC0,8'h50,3,0,1);
        add(1,0,8'h00, 1,8'h51,8'hD0, 1,0, 0,8'h00,0,8'h00, 8'h00,8'h00,0,0,0);
        add(1,0,8'h00, 0,8'h00,8'h00, 0,0, 1,8'h00,0,8'h00, 8'h00,8'h00,0,0,0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", act_a(), '0);
        chk("reset_b", act_b(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].claim, tbl[i].eoi, tbl[i].eoi_id, tbl[i].req,
                 tbl[i].id, tbl[i].lvl, tbl[i].wdt, tbl[i].ndm);
            chk($sformatf("row%0d", i), act_a(), tbl[i].exp);
        end

        // Fill the depth-2 instance, then claim once more.
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 8'h00, 1, 8'(8'h60 + k), 8'(8'h10 * (k + 1)), 0, 0);
            step(1, 0, 8'h00, 1, 8'(8'h60 + k), 8'(8'h10 * (k + 1)), 0, 0);
            if (k == 0)
                chk("ovf_claim0", act_b(),
                    pk(1, 8'h60, 1, 8'h60, 8'h10, 8'h60, 1, 0, 0));
            else if (k == 1)
                chk("ovf_claim1", act_b(),
                    pk(1, 8'h61, 1, 8'h61, 8'h20, 8'h61, 2, 0, 0));
            else begin
                chk("ovf_full", act_b(),
                    pk(1, 8'h00, 0, 8'h00, 8'h20, 8'h61, 2, 1, 0));
                chk("depth3", act_a(),
                    pk(1, 8'h62, 1, 8'h62, 8'h30, 8'h62, 3, 0, 0));
            end
            step(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        end

        // Asynchronous reset between edges must clear outputs at once.
        step(0, 0, 8'h00, 1, 8'h70, 8'h70, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_a", act_a(), '0);
        chk("async_b", act_b(), '0);
        #2;
        rst_n = 1'b1;
        step(1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        chk("post_async", act_a(), pk(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
